// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port synchronous RAM between instruction fetch and load/store.
// Optional macro ARB_MMIO_EN: decode d_addr[31:28]==4'h2 as MMIO (halt register, zero loads).
module mem_port_arbiter #(
  parameter int XLEN         = 32,
  parameter int AW           = 20,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic            if_ready,
  output logic            if_valid,
  output logic [XLEN-1:0] if_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  output logic            d_ready,
  output logic            d_valid,
  output logic [XLEN-1:0] d_rdata,
  output logic            ram_en,
  output logic            ram_we,
  output logic [AW-1:0]   ram_addr,
  output logic [XLEN-1:0] ram_wdata,
  input  logic [XLEN-1:0] ram_rdata,
  output logic            halt
);

  // Handshake: a request is held with its address until ready=1 in the same cycle;
  // the matching valid pulses exactly one cycle later, carrying the RAM read data.
  logic [3:0]      starve_cnt;
  logic            force_i, grant_d, grant_i, d_ram, d_mmio;
  logic            i_pend, d_pend, d_ld_ram, d_ld_zero;
  logic [XLEN-1:0] if_hold, d_hold;
  logic            unused_bits;

  assign unused_bits = ^{if_addr[0], if_addr[XLEN-1:AW+1], d_addr[0], d_addr[XLEN-1:AW+1]};

`ifdef ARB_MMIO_EN
  logic halt_q;
  assign d_mmio = (d_addr[31:28] == 4'h2);
  assign halt   = halt_q;
`else
  assign d_mmio = 1'b0;
  assign halt   = 1'b0;
`endif

  always_comb begin
    force_i   = if_req && (starve_cnt >= 4'(STARVE_LIMIT));
    grant_d   = d_req && !force_i;
    // An MMIO data access leaves the RAM free, so fetch may take it in the same cycle.
    grant_i   = if_req && (!grant_d || d_mmio);
    d_ram     = grant_d && !d_mmio;
    ram_en    = d_ram || grant_i;
    ram_we    = d_ram && d_we;
    ram_addr  = '0;
    ram_wdata = '0;
    if (d_ram) begin
      ram_addr  = d_addr[AW:1];
      ram_wdata = d_wdata;
    end else if (grant_i) begin
      ram_addr  = if_addr[AW:1];
    end
    if_ready  = grant_i;
    d_ready   = grant_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      starve_cnt <= '0;
      i_pend     <= 1'b0;
      d_pend     <= 1'b0;
      d_ld_ram   <= 1'b0;
      d_ld_zero  <= 1'b0;
      if_hold    <= '0;
      d_hold     <= '0;
    end else begin
      if (!if_req || grant_i)
        starve_cnt <= '0;
      else if (starve_cnt != 4'd15)
        starve_cnt <= starve_cnt + 4'd1;
      i_pend    <= grant_i;
      d_pend    <= grant_d;
      d_ld_ram  <= d_ram && !d_we;
      d_ld_zero <= grant_d && d_mmio && !d_we;
      if (i_pend)
        if_hold <= ram_rdata;
      if (d_ld_ram)
        d_hold <= ram_rdata;
      else if (d_ld_zero)
        d_hold <= '0;
    end
  end

`ifdef ARB_MMIO_EN
  always_ff @(posedge clock) begin
    if (reset)
      halt_q <= 1'b0;
    else if (grant_d && d_mmio && d_we && d_addr[31:0] == 32'h2000_0000 && d_wdata[31:0] == 32'd1)
      halt_q <= 1'b1;
  end
`endif

  // Read data is presented straight from the RAM in the valid cycle and held afterwards.
  assign if_valid = i_pend;
  assign if_rdata = i_pend ? ram_rdata : if_hold;
  assign d_valid  = d_pend;
  assign d_rdata  = d_ld_ram ? ram_rdata : (d_ld_zero ? '0 : d_hold);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a behavioural 1-cycle-latency RAM.
// Build with +define+ARB_MMIO_EN to exercise the MMIO/halt variant.
module tb_mem_port_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_ready, if_valid;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_ready, d_valid;
  logic [31:0] d_rdata;
  logic        ram_en, ram_we;
  logic [19:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = '0;
  logic        halt;

  int tests_run = 0;
  int tests_failed = 0;

  mem_port_arbiter #(.XLEN(32), .AW(20), .STARVE_LIMIT(4)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_valid(if_valid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_valid(d_valid), .d_rdata(d_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .halt(halt)
  );

  always #5 clock = ~clock;

  // RAM model: unwritten words read back a fixed pattern per address
  logic [31:0] mem [0:255];
  bit          written [0:255];

  function automatic logic [31:0] init_val(input logic [7:0] a);
    case (a)
      8'h20:   init_val = 32'hDEAD_BEEF;
      8'h00:   init_val = 32'h1111_0000;
      8'h02:   init_val = 32'h2222_0004;
      8'h04:   init_val = 32'h3333_0008;
      default: init_val = {24'hA5A5A5, a};
    endcase
  endfunction

  always @(posedge clock) begin
    if (ram_en) begin
      if (ram_we) begin
        mem[ram_addr[7:0]]     <= ram_wdata;
        written[ram_addr[7:0]] <= 1'b1;
      end else begin
        ram_rdata <= written[ram_addr[7:0]] ? mem[ram_addr[7:0]] : init_val(ram_addr[7:0]);
      end
    end
  end

  task automatic idle();
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_wdata = '0;
  endtask

  task automatic drive_d(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    repeat (2) @(negedge clock);
    #1;
    tests_run++;
    if ({if_ready, if_valid, if_rdata, d_ready, d_valid, d_rdata, ram_en, ram_we, ram_addr, ram_wdata, halt} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: if_v=%b if_rd=%h d_v=%b d_rd=%h ram_en=%b halt=%b, all must be 0",
               if_valid, if_rdata, d_valid, d_rdata, ram_en, halt);
    end
    tests_run++;
    if (dut.starve_cnt !== 4'd0) begin
      tests_failed++;
      $display("FAIL reset_starve: got %0d expected 0", dut.starve_cnt);
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_load();
    @(negedge clock);
    drive_d(1'b0, 32'h40, 32'h0);
    #1;
    tests_run++;
    if ({d_ready, if_ready, ram_en, ram_we, ram_addr} !== {1'b1, 1'b0, 1'b1, 1'b0, 20'h00020}) begin
      tests_failed++;
      $display("FAIL load_grant: d_rdy=%b i_rdy=%b en=%b we=%b addr=%h expected 1 0 1 0 00020",
               d_ready, if_ready, ram_en, ram_we, ram_addr);
    end
    @(negedge clock);
    idle();
    #1;
    tests_run++;
    if (d_valid !== 1'b1 || d_rdata !== 32'hDEAD_BEEF || if_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL load_resp: d_valid=%b d_rdata=%h if_valid=%b expected 1 deadbeef 0", d_valid, d_rdata, if_valid);
    end
    @(negedge clock);
    #1;
    tests_run++;
    if (d_valid !== 1'b0 || d_rdata !== 32'hDEAD_BEEF) begin
      tests_failed++;
      $display("FAIL load_hold: d_valid=%b d_rdata=%h expected 0 deadbeef", d_valid, d_rdata);
    end
  endtask

  task automatic test_store();
    @(negedge clock);
    drive_d(1'b1, 32'h100, 32'h1234_5678);
    #1;
    tests_run++;
    if ({d_ready, ram_en, ram_we, ram_addr, ram_wdata} !== {1'b1, 1'b1, 1'b1, 20'h00080, 32'h1234_5678}) begin
      tests_failed++;
      $display("FAIL store_grant: d_rdy=%b en=%b we=%b addr=%h wdata=%h expected 1 1 1 00080 12345678",
               d_ready, ram_en, ram_we, ram_addr, ram_wdata);
    end
    @(negedge clock);
    drive_d(1'b0, 32'h100, 32'h0);
    #1;
    tests_run++;
    if (d_valid !== 1'b1 || d_rdata !== 32'hDEAD_BEEF) begin
      tests_failed++;
      $display("FAIL store_done: d_valid=%b d_rdata=%h expected 1 deadbeef (unchanged)", d_valid, d_rdata);
    end
    @(negedge clock);
    idle();
    #1;
    tests_run++;
    if (d_valid !== 1'b1 || d_rdata !== 32'h1234_5678) begin
      tests_failed++;
      $display("FAIL store_readback: d_valid=%b d_rdata=%h expected 1 12345678", d_valid, d_rdata);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_data [0:2];
    exp_data[0] = 32'h1111_0000;
    exp_data[1] = 32'h2222_0004;
    exp_data[2] = 32'h3333_0008;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (i < 3) begin
        if_req = 1'b1;
        if_addr = 32'(4 * i);
      end else begin
        idle();
      end
      #1;
      tests_run++;
      if (if_ready !== (i < 3) || ram_addr !== ((i < 3) ? 20'(2 * i) : 20'h0)) begin
        tests_failed++;
        $display("FAIL b2b_ready[%0d]: if_ready=%b ram_addr=%h expected %b %h", i, if_ready, ram_addr,
                 (i < 3), ((i < 3) ? 20'(2 * i) : 20'h0));
      end
      if (i > 0) begin
        tests_run++;
        if (if_valid !== 1'b1 || if_rdata !== exp_data[i-1]) begin
          tests_failed++;
          $display("FAIL b2b_valid[%0d]: if_valid=%b if_rdata=%h expected 1 %h", i, if_valid, if_rdata, exp_data[i-1]);
        end
      end
    end
    @(negedge clock);
    #1;
    tests_run++;
    if (if_valid !== 1'b0 || if_rdata !== 32'h3333_0008) begin
      tests_failed++;
      $display("FAIL b2b_tail: if_valid=%b if_rdata=%h expected 0 33330008", if_valid, if_rdata);
    end
  endtask

  task automatic test_contention();
    logic [9:0] exp_i;
    int         valid_cnt;
    exp_i = 10'b10_0001_0000;
    valid_cnt = 0;
    for (int i = 0; i <= 10; i++) begin
      @(negedge clock);
      if (i < 10) begin
        if_req = 1'b1; if_addr = 32'h8;
        drive_d(1'b0, 32'h40, 32'h0);
      end else begin
        idle();
      end
      #1;
      if (i > 0 && if_valid === 1'b1) begin
        valid_cnt++;
        tests_run++;
        if (if_rdata !== 32'h3333_0008) begin
          tests_failed++;
          $display("FAIL contend_idata[%0d]: if_rdata=%h expected 33330008", i, if_rdata);
        end
      end
      if (i < 10) begin
        tests_run++;
        if (if_ready !== exp_i[i] || d_ready !== !exp_i[i]) begin
          tests_failed++;
          $display("FAIL contend_grant[%0d]: if_ready=%b d_ready=%b expected %b %b", i, if_ready, d_ready,
                   exp_i[i], !exp_i[i]);
        end
      end
    end
    tests_run++;
    if (valid_cnt != 2) begin
      tests_failed++;
      $display("FAIL contend_ivalid_count: got %0d expected 2", valid_cnt);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clock);
    if_req = 1'b1; if_addr = 32'h8;
    drive_d(1'b0, 32'h40, 32'h0);
    @(negedge clock);
    #1;
    tests_run++;
    if (d_ready !== 1'b1 || dut.starve_cnt !== 4'd1) begin
      tests_failed++;
      $display("FAIL rstmid_pre: d_ready=%b starve=%0d expected 1 1", d_ready, dut.starve_cnt);
    end
    reset = 1'b1;
    @(negedge clock);
    idle();
    #1;
    tests_run++;
    if ({d_valid, d_rdata, if_valid, if_rdata, halt} !== '0 || dut.starve_cnt !== 4'd0) begin
      tests_failed++;
      $display("FAIL rstmid_drop: d_valid=%b d_rdata=%h if_valid=%b if_rdata=%h halt=%b starve=%0d expected all 0",
               d_valid, d_rdata, if_valid, if_rdata, halt, dut.starve_cnt);
    end
    reset = 1'b0;
    @(negedge clock);
    #1;
    tests_run++;
    if (d_valid !== 1'b0 || if_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rstmid_after: d_valid=%b if_valid=%b expected 0 0", d_valid, if_valid);
    end
  endtask

  task automatic test_mmio();
    @(negedge clock);
    drive_d(1'b0, 32'h40, 32'h0);
    @(negedge clock);
    drive_d(1'b1, 32'h2000_0000, 32'd1);
    #1;
`ifdef ARB_MMIO_EN
    tests_run++;
    if (ram_en !== 1'b0 || d_ready !== 1'b1 || halt !== 1'b0) begin
      tests_failed++;
      $display("FAIL mmio_store1: ram_en=%b d_ready=%b halt=%b expected 0 1 0", ram_en, d_ready, halt);
    end
    @(negedge clock);
    drive_d(1'b1, 32'h2000_0000, 32'd2);
    if_req = 1'b1; if_addr = 32'h4;
    #1;
    tests_run++;
    if ({halt, d_valid, d_ready, if_ready, ram_en, ram_we, ram_addr} !== {4'b1111, 2'b10, 20'h00002}) begin
      tests_failed++;
      $display("FAIL mmio_store2: halt=%b d_v=%b d_rdy=%b i_rdy=%b en=%b we=%b addr=%h expected 1 1 1 1 1 0 00002",
               halt, d_valid, d_ready, if_ready, ram_en, ram_we, ram_addr);
    end
    @(negedge clock);
    if_req = 1'b0;
    drive_d(1'b0, 32'h2000_0004, 32'h0);
    #1;
    tests_run++;
    if (halt !== 1'b1 || if_valid !== 1'b1 || if_rdata !== 32'h2222_0004 || ram_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL mmio_sticky: halt=%b if_valid=%b if_rdata=%h ram_en=%b expected 1 1 22220004 0",
               halt, if_valid, if_rdata, ram_en);
    end
    @(negedge clock);
    idle();
    #1;
    tests_run++;
    if (d_valid !== 1'b1 || d_rdata !== 32'h0 || halt !== 1'b1) begin
      tests_failed++;
      $display("FAIL mmio_load: d_valid=%b d_rdata=%h halt=%b expected 1 00000000 1", d_valid, d_rdata, halt);
    end
`else
    tests_run++;
    if ({ram_en, ram_we, d_ready, ram_addr, ram_wdata} !== {3'b111, 20'h00000, 32'd1}) begin
      tests_failed++;
      $display("FAIL nommio_store: en=%b we=%b d_rdy=%b addr=%h wdata=%h expected 1 1 1 00000 00000001",
               ram_en, ram_we, d_ready, ram_addr, ram_wdata);
    end
    @(negedge clock);
    idle();
    #1;
    tests_run++;
    if (halt !== 1'b0 || d_valid !== 1'b1 || d_rdata !== 32'hDEAD_BEEF) begin
      tests_failed++;
      $display("FAIL nommio_halt: halt=%b d_valid=%b d_rdata=%h expected 0 1 deadbeef", halt, d_valid, d_rdata);
    end
`endif
    @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_back_to_back();
    test_contention();
    test_reset_mid();
    test_mmio();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-port synchronous RAM between the CPU instruction-fetch port and the load/store port. It is used in the FPGA build, where a true dual-port RAM is not available. Each cycle it grants at most one request. Data accesses have priority, and a starvation counter guarantees fetch progress. Read data returns one cycle after the grant, matching the 1-cycle read latency of the RAM.

Parameters:
XLEN, 32, data/address width of both requester ports
AW, 20, RAM halfword-address width; ram_addr = req_addr[AW:1]
STARVE_LIMIT, 4, consecutive denied fetch cycles after which fetch is forced to win (range 1..15)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
if_req  in  1  fetch request, held until accepted
if_addr  in  XLEN  fetch byte address
if_ready  out  1  fetch accepted this cycle
if_valid  out  1  fetch data valid (1 cycle after if_ready)
if_rdata  out  XLEN  fetch data
d_req  in  1  data request, held until accepted
d_we  in  1  1 = store, 0 = load
d_addr  in  XLEN  data byte address
d_wdata  in  XLEN  store data
d_ready  out  1  data access accepted this cycle
d_valid  out  1  load data valid / store done (1 cycle after d_ready)
d_rdata  out  XLEN  load data
ram_en  out  1  RAM access enable
ram_we  out  1  RAM write enable
ram_addr  out  AW  RAM halfword address
ram_wdata  out  XLEN  RAM write data
ram_rdata  in  XLEN  RAM read data, valid the cycle after ram_en
halt  out  1  sticky simulation-halt flag (see Optional Feature)

Behaviour:
- Grant decision is combinational within the cycle.
  - Grant D if d_req and !force_i.
  - Else grant I if if_req.
  - Else no grant.
  - force_i = if_req && (starve_cnt >= STARVE_LIMIT).
- The granted port sees ready=1 in the same cycle. ram_en=1, and ram_we=d_we when D is granted (0 for I). ram_addr and ram_wdata are driven from the granted port; ram_wdata is driven from D only.
- The non-granted port sees ready=0 and must hold its request and address.
- starve_cnt (4 bits):
  - reset to 0 when I is granted or if_req=0;
  - +1 when if_req=1 and I is not granted;
  - saturates at 15.
- Response pipeline:
  - resp_sel register records which port (I, D, or none) was granted last cycle.
  - Next cycle, the matching valid is pulsed for exactly 1 cycle, and its rdata is loaded from ram_rdata. Stores also pulse d_valid; d_rdata is left unchanged.
- if_rdata and d_rdata hold their last value until the next valid on that port.
- Back-to-back grants are allowed every cycle with no bubble. Full throughput is one access per cycle.
- Reset:
  - All outputs go to 0, including rdata registers, halt, and starve_cnt; resp_sel = none.
  - A grant made in the same cycle as reset produces no valid afterwards.
  - Reset asserted while a response is pending drops that response.
- Simultaneous if_req and d_req with starve_cnt < STARVE_LIMIT: D wins and starve_cnt increments.

Optional Feature:
ARB_MMIO_EN.
- Defined:
  - D accesses with d_addr[31:28] == 4'h2 are MMIO. They are never forwarded to RAM (ram_en=0 that cycle) and are still acknowledged with d_ready.
  - A store to 32'h20000000 with d_wdata[31:0] == 1 sets halt (sticky until reset).
  - MMIO loads return d_rdata = 0 with d_valid the next cycle.
  - The fetch port is not MMIO-decoded.
  - An I request may use the RAM in the same cycle as an MMIO D access; force_i logic is unchanged.
- Undefined: halt is tied to 0, and every address is forwarded to RAM truncated to ram_addr.

Test Plan:
- Load only: d_req=1, d_we=0, d_addr=0x40 → ram_addr=0x20, d_ready=1 in cycle 0; RAM returns 0xDEADBEEF, giving d_valid=1 and d_rdata=0xDEADBEEF in cycle 1.
- Contention: if_req and d_req held high for 10 cycles with STARVE_LIMIT=4 → grants are D,D,D,D,I,D,D,D,D,I; if_valid pulses exactly 2 times.
- Store: d_we=1, d_addr=0x100, d_wdata=0x12345678 → ram_we=1, ram_addr=0x80, ram_wdata=0x12345678; d_valid=1 next cycle; a later read of 0x100 returns 0x12345678.
- Back-to-back fetch: if_addr=0,4,8 on consecutive cycles with d_req=0 → three consecutive if_ready, then three consecutive if_valid, each delayed by one cycle.
- Reset mid-operation: grant a D load, assert reset on the next edge → no d_valid; all outputs 0; starve_cnt=0.
- With ARB_MMIO_EN: store 1 to 0x20000000 → ram_en=0, d_ready=1, halt=1 from the next cycle. Store 2 to the same address → halt stays 1. Without the macro, the same store gives ram_en=1, ram_addr=0x00000, and halt=0.
